// File: rtl/vga_axil_pkg.sv
// Shared AXI4-Lite types for the VGA register fabric.
// Widths, response codes and master FSM state encodings.
package vga_axil_pkg;

    localparam int AXIL_ADDR_WIDTH   = 32;
    localparam int AXIL_DATA_WIDTH   = 32;
    localparam int AXIL_STRB_WIDTH   = AXIL_DATA_WIDTH / 8;
    localparam int AXIL_WIDTH_OFFSET = 2;

    typedef logic [AXIL_ADDR_WIDTH-1:0] axil_addr_t;
    typedef logic [AXIL_DATA_WIDTH-1:0] axil_data_t;
    typedef logic [AXIL_STRB_WIDTH-1:0] axil_strb_t;

    typedef enum logic [1:0] {
        AXIL_RESP_OKAY   = 2'b00,
        AXIL_RESP_EXOKAY = 2'b01,
        AXIL_RESP_SLVERR = 2'b10,
        AXIL_RESP_DECERR = 2'b11
    } axil_resp_e;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_ADDR_DATA = 2'd1,
        W_RESP      = 2'd2
    } axil_wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } axil_rd_state_e;

endpackage

// File: rtl/vga_axil_if.sv
// AXI4-Lite channel bundle between VGA masters and slaves.
// Master drives valids/payloads and B/R readies; slave the rest.
interface vga_axil_if #(
    parameter int ADDR_WIDTH = vga_axil_pkg::AXIL_ADDR_WIDTH,
    parameter int DATA_WIDTH = vga_axil_pkg::AXIL_DATA_WIDTH
);

    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;

    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;

    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;

    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr,
        output rready,
        input  awready, wready,
        input  bvalid, bresp,
        input  arready,
        input  rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr,
        input  rready,
        output awready, wready,
        output bvalid, bresp,
        output arready,
        output rvalid, rdata, rresp
    );

endinterface

// File: rtl/vga_axil_master_fsm.sv
// AXI4-Lite master: native single-word requests to AW/W/B and AR/R.
// Independent write and read FSMs, all outputs registered.
module vga_axil_master_fsm
    import vga_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = AXIL_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXIL_DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    vga_axil_if.master              axil_if,
    input  logic                    wr_req_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
    output logic                    wr_ready_o,
    output logic                    wr_done_o,
    output logic [1:0]              wr_resp_o,
    input  logic                    rd_req_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic                    rd_ready_o,
    output logic                    rd_done_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic [1:0]              rd_resp_o
);

    axil_wr_state_e          wr_state_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    wr_ready_q;
    logic                    wr_done_q;
    axil_resp_e              wr_resp_q;

    axil_rd_state_e          rd_state_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic                    rd_ready_q;
    logic                    rd_done_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    axil_resp_e              rd_resp_q;

    logic aw_hs;
    logic w_hs;
    logic aw_fin;
    logic w_fin;
    logic b_hs;
    logic r_hs;

    // A channel is finished once its valid has already dropped
    // or its handshake completes in the current cycle.
    assign aw_hs  = awvalid_q && axil_if.awready;
    assign w_hs   = wvalid_q && axil_if.wready;
    assign aw_fin = !awvalid_q || axil_if.awready;
    assign w_fin  = !wvalid_q || axil_if.wready;
    assign b_hs   = bready_q && axil_if.bvalid;
    assign r_hs   = rready_q && axil_if.rvalid;

    // Write FSM: issue AW and W together, retire each independently, collect B.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_state_q <= W_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_ready_q <= 1'b1;
            wr_done_q  <= 1'b0;
            wr_resp_q  <= AXIL_RESP_OKAY;
        end else begin
            wr_done_q <= 1'b0;
            unique case (wr_state_q)
                W_IDLE: begin
                    if (wr_req_i) begin
                        awaddr_q   <= wr_addr_i;
                        wdata_q    <= wr_data_i;
                        wstrb_q    <= wr_strb_i;
                        awvalid_q  <= 1'b1;
                        wvalid_q   <= 1'b1;
                        wr_ready_q <= 1'b0;
                        wr_state_q <= W_ADDR_DATA;
                    end
                end
                W_ADDR_DATA: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_fin && w_fin) begin
                        bready_q   <= 1'b1;
                        wr_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        wr_resp_q  <= axil_resp_e'(axil_if.bresp);
                        wr_done_q  <= 1'b1;
                        bready_q   <= 1'b0;
                        wr_ready_q <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: begin
                    wr_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: issue AR, then accept one R beat.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rd_state_q <= R_IDLE;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            araddr_q   <= '0;
            rd_ready_q <= 1'b1;
            rd_done_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_resp_q  <= AXIL_RESP_OKAY;
        end else begin
            rd_done_q <= 1'b0;
            unique case (rd_state_q)
                R_IDLE: begin
                    if (rd_req_i) begin
                        araddr_q   <= rd_addr_i;
                        arvalid_q  <= 1'b1;
                        rd_ready_q <= 1'b0;
                        rd_state_q <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (arvalid_q && axil_if.arready) begin
                        arvalid_q  <= 1'b0;
                        rready_q   <= 1'b1;
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        rd_data_q  <= axil_if.rdata;
                        rd_resp_q  <= axil_resp_e'(axil_if.rresp);
                        rd_done_q  <= 1'b1;
                        rready_q   <= 1'b0;
                        rd_ready_q <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: begin
                    rd_state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign axil_if.awvalid = awvalid_q;
    assign axil_if.awaddr  = awaddr_q;
    assign axil_if.wvalid  = wvalid_q;
    assign axil_if.wdata   = wdata_q;
    assign axil_if.wstrb   = wstrb_q;
    assign axil_if.bready  = bready_q;
    assign axil_if.arvalid = arvalid_q;
    assign axil_if.araddr  = araddr_q;
    assign axil_if.rready  = rready_q;

    assign wr_ready_o = wr_ready_q;
    assign wr_done_o  = wr_done_q;
    assign wr_resp_o  = wr_resp_q;
    assign rd_ready_o = rd_ready_q;
    assign rd_done_o  = rd_done_q;
    assign rd_data_o  = rd_data_q;
    assign rd_resp_o  = rd_resp_q;

endmodule

// File: tb/tb_vga_axil_master_fsm.sv
// Bench for vga_axil_master_fsm with a delay-configurable slave model.
// Scoreboard queues hold expected B/R results until done pulses arrive.
module tb_vga_axil_master_fsm;
    import vga_axil_pkg::*;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    logic        wr_req = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        wr_ready;
    logic        wr_done;
    logic [1:0]  wr_resp;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        rd_ready;
    logic        rd_done;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    vga_axil_if axil ();

    vga_axil_master_fsm dut (
        .clk_i     (clk),
        .arst_n_i  (arst_n),
        .axil_if   (axil),
        .wr_req_i  (wr_req),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .wr_strb_i (wr_strb),
        .wr_ready_o(wr_ready),
        .wr_done_o (wr_done),
        .wr_resp_o (wr_resp),
        .rd_req_i  (rd_req),
        .rd_addr_i (rd_addr),
        .rd_ready_o(rd_ready),
        .rd_done_o (rd_done),
        .rd_data_o (rd_data),
        .rd_resp_o (rd_resp)
    );

    // ---------------- slave model ----------------
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic        preload_en = 1'b0;
    logic [31:0] preload_addr = '0;
    logic [31:0] preload_data = '0;

    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic aw_got, w_got, ar_got;
    logic [31:0] s_awaddr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [31:0] smem [128];

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    assign axil.awready = axil.awvalid && !aw_got && (aw_cnt >= aw_dly);
    assign axil.wready  = axil.wvalid && !w_got && (w_cnt >= w_dly);
    assign axil.bvalid  = aw_got && w_got && (b_cnt >= b_dly);
    assign axil.bresp   = bresp_cfg;
    assign axil.arready = axil.arvalid && !ar_got && (ar_cnt >= ar_dly);
    assign axil.rvalid  = ar_got && (r_cnt >= r_dly);
    assign axil.rdata   = s_rdata;
    assign axil.rresp   = rresp_cfg;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0;
            for (int i = 0; i < 128; i++) smem[i] <= '0;
        end else begin
            if (preload_en) smem[preload_addr[8:2]] <= preload_data;
            if (axil.awvalid && axil.awready) begin
                aw_got <= 1'b1; s_awaddr <= axil.awaddr; aw_cnt <= 0;
            end else if (axil.awvalid && !aw_got) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (axil.wvalid && axil.wready) begin
                w_got <= 1'b1; s_wdata <= axil.wdata; s_wstrb <= axil.wstrb; w_cnt <= 0;
            end else if (axil.wvalid && !w_got) begin
                w_cnt <= w_cnt + 1;
            end
            if (axil.bvalid && axil.bready) begin
                smem[s_awaddr[8:2]] <= merge(smem[s_awaddr[8:2]], s_wdata, s_wstrb);
                aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end else if (aw_got && w_got) begin
                b_cnt <= b_cnt + 1;
            end
            if (axil.arvalid && axil.arready) begin
                ar_got <= 1'b1; s_rdata <= smem[axil.araddr[8:2]]; r_cnt <= 0; ar_cnt <= 0;
            end else if (axil.arvalid && !ar_got) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (axil.rvalid && axil.rready) begin
                ar_got <= 1'b0;
            end else if (ar_got) begin
                r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- monitors ----------------
    int wr_cnt = 0, rd_cnt = 0;
    logic [1:0]  wr_log [256];
    logic [31:0] rd_log_data [256];
    logic [1:0]  rd_log_resp [256];
    int stab_err = 0, pulse_err = 0;
    logic p_rst = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
    logic p_arv = 1'b0, p_arr = 1'b0, p_wd = 1'b0, p_rd = 1'b0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
    logic [3:0]  p_wstrb = '0;

    always @(negedge clk) begin
        if (arst_n && wr_done) begin
            wr_log[wr_cnt[7:0]] <= wr_resp;
            wr_cnt <= wr_cnt + 1;
        end
        if (arst_n && rd_done) begin
            rd_log_data[rd_cnt[7:0]] <= rd_data;
            rd_log_resp[rd_cnt[7:0]] <= rd_resp;
            rd_cnt <= rd_cnt + 1;
        end
        if (arst_n && p_rst) begin
            if (p_awv && !p_awr && (!axil.awvalid || axil.awaddr !== p_awaddr))
                stab_err <= stab_err + 1;
            if (p_awv && p_awr && axil.awvalid) stab_err <= stab_err + 1;
            if (p_wv && !p_wr && (!axil.wvalid || axil.wdata !== p_wdata ||
                                  axil.wstrb !== p_wstrb))
                stab_err <= stab_err + 1;
            if (p_wv && p_wr && axil.wvalid) stab_err <= stab_err + 1;
            if (p_arv && !p_arr && (!axil.arvalid || axil.araddr !== p_araddr))
                stab_err <= stab_err + 1;
            if (p_arv && p_arr && axil.arvalid) stab_err <= stab_err + 1;
            if ((p_wd && wr_done) || (p_rd && rd_done)) pulse_err <= pulse_err + 1;
        end
        p_rst <= arst_n;
        p_awv <= axil.awvalid; p_awr <= axil.awready; p_awaddr <= axil.awaddr;
        p_wv <= axil.wvalid; p_wr <= axil.wready;
        p_wdata <= axil.wdata; p_wstrb <= axil.wstrb;
        p_arv <= axil.arvalid; p_arr <= axil.arready; p_araddr <= axil.araddr;
        p_wd <= wr_done; p_rd <= rd_done;
    end

    // ---------------- checking ----------------
    int pass_cnt = 0, total_cnt = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    logic [1:0] exp_wr_q [$];
    rd_exp_t    exp_rd_q [$];
    int wr_ptr = 0, rd_ptr = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [8];
    logic [31:0] sb_mem [8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        total_cnt++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_wr(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] er);
        int n = 0;
        while (!wr_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!wr_ready) fail_timeout("wr_ready");
        wr_req = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        tick(1);
        wr_req = 1'b0;
        exp_wr_q.push_back(er);
    endtask

    task automatic issue_rd(input logic [31:0] a, input logic [31:0] ed,
                            input logic [1:0] er);
        int n = 0;
        rd_exp_t e;
        while (!rd_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (!rd_ready) fail_timeout("rd_ready");
        rd_req = 1'b1; rd_addr = a;
        tick(1);
        rd_req = 1'b0;
        e.data = ed; e.resp = er;
        exp_rd_q.push_back(e);
    endtask

    task automatic sb_wr(input string name);
        int n = 0;
        logic [1:0] er;
        while (wr_cnt <= wr_ptr && n < 300) begin
            tick(1);
            n++;
        end
        if (exp_wr_q.size() == 0) begin
            fail_timeout({name, "_noexp"});
        end else begin
            er = exp_wr_q.pop_front();
            if (wr_cnt <= wr_ptr) fail_timeout(name);
            else check({name, "_bresp"}, wr_log[wr_ptr[7:0]], er);
        end
        if (wr_cnt > wr_ptr) wr_ptr++;
    endtask

    task automatic sb_rd(input string name);
        int n = 0;
        rd_exp_t e;
        while (rd_cnt <= rd_ptr && n < 300) begin
            tick(1);
            n++;
        end
        if (exp_rd_q.size() == 0) begin
            fail_timeout({name, "_noexp"});
        end else begin
            e = exp_rd_q.pop_front();
            if (rd_cnt <= rd_ptr) begin
                fail_timeout(name);
            end else begin
                check({name, "_rdata"}, rd_log_data[rd_ptr[7:0]], e.data);
                check({name, "_rresp"}, rd_log_resp[rd_ptr[7:0]], e.resp);
            end
        end
        if (rd_cnt > rd_ptr) rd_ptr++;
    endtask

    task automatic set_dly(input int aw, input int w, input int b,
                           input int ar, input int r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    initial begin
        int c0w, c0r, idx;
        logic [31:0] a, d;
        logic [3:0] s;

        vecs[0] = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 32'h14, 32'h11223344, 4'h5, 2'b00, 32'h0};
        vecs[2] = '{1'b0, 32'h14, 32'h0,        4'h0, 2'b00, 32'h00220044};
        vecs[3] = '{1'b1, 32'h14, 32'hAABBCCDD, 4'hA, 2'b10, 32'h0};
        vecs[4] = '{1'b0, 32'h14, 32'h0,        4'h0, 2'b11, 32'hAA22CC44};
        vecs[5] = '{1'b1, 32'h18, 32'h00000001, 4'hF, 2'b01, 32'h0};
        vecs[6] = '{1'b0, 32'h18, 32'h0,        4'h0, 2'b00, 32'h00000001};
        vecs[7] = '{1'b0, 32'h1C, 32'h0,        4'h0, 2'b10, 32'h0};

        // reset state
        tick(3);
        arst_n = 1'b1;
        #1;
        check("rst_valids", {axil.awvalid, axil.wvalid, axil.bready,
                             axil.arvalid, axil.rready}, 0);
        check("rst_ready", {wr_ready, rd_ready}, 2'b11);
        check("rst_done", {wr_done, rd_done}, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_resp", {wr_resp, rd_resp}, 0);

        // zero-wait write latency
        set_dly(0, 0, 0, 0, 0);
        tick(1);
        issue_wr(32'h10, 32'hDEADBEEF, 4'hF, 2'b00);
        check("lat_n1_valids", {axil.awvalid, axil.wvalid, wr_ready}, 3'b110);
        check("lat_n1_awaddr", axil.awaddr, 32'h10);
        check("lat_n1_wdata", axil.wdata, 32'hDEADBEEF);
        tick(1);
        check("lat_n2_bready", {axil.bready, axil.awvalid, axil.wvalid}, 3'b100);
        tick(1);
        check("lat_n3_done", {wr_done, wr_ready, axil.bready}, 3'b110);
        sb_wr("lat");

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            bresp_cfg = vecs[i].resp;
            rresp_cfg = vecs[i].resp;
            if (vecs[i].wr) begin
                issue_wr(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
                sb_wr($sformatf("vec%0d", i));
            end else begin
                issue_rd(vecs[i].addr, vecs[i].exp_data, vecs[i].resp);
                sb_rd($sformatf("vec%0d", i));
            end
        end
        bresp_cfg = 2'b00;
        rresp_cfg = 2'b00;

        // AW held off, W immediate
        set_dly(5, 0, 0, 0, 0);
        c0w = wr_cnt;
        issue_wr(32'h24, 32'h55AA55AA, 4'hF, 2'b00);
        tick(1);
        check("hsA_w_drop_aw_hold", {axil.wvalid, axil.awvalid}, 2'b01);
        sb_wr("hsA");
        tick(6);
        check("hsA_one_b", wr_cnt - c0w, 1);

        // W held off, AW immediate
        set_dly(0, 5, 0, 0, 0);
        c0w = wr_cnt;
        issue_wr(32'h28, 32'h0F0F0F0F, 4'hF, 2'b00);
        tick(1);
        check("hsB_aw_drop_w_hold", {axil.awvalid, axil.wvalid}, 2'b01);
        sb_wr("hsB");
        tick(6);
        check("hsB_one_b", wr_cnt - c0w, 1);

        // concurrent write and read
        set_dly(0, 0, 0, 0, 0);
        preload_en = 1'b1; preload_addr = 32'h40; preload_data = 32'hCAFE;
        tick(1);
        preload_en = 1'b0;
        wr_req = 1'b1; wr_addr = 32'h20; wr_data = 32'h1234; wr_strb = 4'hF;
        rd_req = 1'b1; rd_addr = 32'h40;
        tick(1);
        wr_req = 1'b0; rd_req = 1'b0;
        exp_wr_q.push_back(2'b00);
        exp_rd_q.push_back('{32'hCAFE, 2'b00});
        check("conc_both_busy", {wr_ready, rd_ready, axil.awvalid, axil.arvalid}, 4'b0011);
        sb_wr("conc");
        sb_rd("conc");
        issue_rd(32'h20, 32'h1234, 2'b00);
        sb_rd("conc_rb");

        // backpressure with ignored requests
        set_dly(0, 0, 7, 0, 4);
        c0w = wr_cnt;
        c0r = rd_cnt;
        wr_req = 1'b1; wr_addr = 32'h30; wr_data = 32'h77; wr_strb = 4'hF;
        rd_req = 1'b1; rd_addr = 32'h40;
        tick(1);
        exp_wr_q.push_back(2'b00);
        exp_rd_q.push_back('{32'hCAFE, 2'b00});
        wr_addr = 32'h34; wr_data = 32'h99;
        rd_addr = 32'h10;
        tick(4);
        wr_req = 1'b0; rd_req = 1'b0;
        sb_wr("bp");
        sb_rd("bp");
        tick(15);
        check("bp_one_wr_done", wr_cnt - c0w, 1);
        check("bp_one_rd_done", rd_cnt - c0r, 1);
        set_dly(0, 0, 0, 0, 0);
        issue_rd(32'h34, 32'h0, 2'b00);
        sb_rd("bp_ignored_wr");

        // reset while waiting in W_RESP
        set_dly(0, 0, 20, 0, 0);
        c0w = wr_cnt;
        c0r = rd_cnt;
        wr_req = 1'b1; wr_addr = 32'h38; wr_data = 32'h5; wr_strb = 4'hF;
        tick(1);
        wr_req = 1'b0;
        tick(3);
        check("rst_mid_in_wresp", {axil.bready, wr_ready}, 2'b10);
        arst_n = 1'b0;
        #1;
        check("rst_mid_idle", {wr_ready, rd_ready, axil.bready,
                               axil.awvalid, axil.wvalid}, 5'b11000);
        tick(2);
        arst_n = 1'b1;
        tick(10);
        check("rst_mid_no_stray", (wr_cnt - c0w) + (rd_cnt - c0r), 0);

        // random traffic checked against a shadow memory
        for (int i = 0; i < 8; i++) sb_mem[i] = '0;
        for (int i = 0; i < 10; i++) begin
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            idx = $urandom_range(0, 7);
            a = 32'h100 + 32'(idx) * 4;
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            issue_wr(a, d, s, 2'b00);
            sb_mem[idx] = merge(sb_mem[idx], d, s);
            sb_wr($sformatf("rnd%0d_w", i));
            tick($urandom_range(0, 10));
            idx = $urandom_range(0, 7);
            issue_rd(32'h100 + 32'(idx) * 4, sb_mem[idx], 2'b00);
            sb_rd($sformatf("rnd%0d_r", i));
            tick($urandom_range(0, 10));
        end

        tick(5);
        check("valid_payload_stability", stab_err, 0);
        check("done_single_cycle", pulse_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
